// File: rtl/huffman_arb_pkg.sv
// rtl/huffman_arb_pkg.sv - shared types and constants for the two-way Huffman coder arbiter
package huffman_arb_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RDWAIT
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way grant selection: live lock owner first, then round-robin
module rr_pick2
    import huffman_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock_owner_valid,
    input  logic       lock_owner,
    output logic       grant
);

    always_comb begin
        grant = REQ0;
        if (lock_owner_valid && req[lock_owner]) begin
            grant = lock_owner;
        end else if (req == 2'b11) begin
            grant = ~last;
        end else if (req[1]) begin
            grant = REQ1;
        end
    end

endmodule

// File: rtl/huffman_arbiter.sv
// rtl/huffman_arbiter.sv - arbitrates two Avalon-MM requesters onto one Huffman coder slave
module huffman_arbiter
    import huffman_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_read,
    input  logic              req0_write,
    input  logic [DATA_W-1:0] req0_writedata,
    input  logic              req0_lock,
    output logic              req0_waitrequest,
    output logic [DATA_W-1:0] req0_readdata,
    output logic              req0_readdatavalid,
    input  logic              req1_read,
    input  logic              req1_write,
    input  logic [DATA_W-1:0] req1_writedata,
    input  logic              req1_lock,
    output logic              req1_waitrequest,
    output logic [DATA_W-1:0] req1_readdata,
    output logic              req1_readdatavalid,
    output logic              cod_chipselect,
    output logic              cod_read,
    output logic              cod_write,
    output logic [DATA_W-1:0] cod_writedata,
    input  logic [DATA_W-1:0] cod_readdata,
    output logic              busy
);

    state_t state;
    logic   grant;
    logic   last;
    logic   lock_valid;
    logic   lock_owner;
    logic   pick;

    logic [1:0] req_any;
    logic [1:0] lock_in;
    logic       owner_lock_live;
    logic       issue;
    logic       g_read;
    logic       g_write;
    logic       g_lock;
    logic [DATA_W-1:0] g_wdata;

    assign req_any = {req1_read | req1_write, req0_read | req0_write};
    assign lock_in = {req1_lock, req0_lock};
    // A lock only steers selection while its owner still asserts lock.
    assign owner_lock_live = lock_valid & lock_in[lock_owner];

    rr_pick2 u_pick (
        .req              (req_any),
        .last             (last),
        .lock_owner_valid (owner_lock_live),
        .lock_owner       (lock_owner),
        .grant            (pick)
    );

    assign g_read  = grant ? req1_read      : req0_read;
    assign g_write = grant ? req1_write     : req0_write;
    assign g_lock  = grant ? req1_lock      : req0_lock;
    assign g_wdata = grant ? req1_writedata : req0_writedata;
    assign issue   = (state == ST_ISSUE);

    // Write beats read when both are held; the read is simply not issued.
    assign cod_chipselect   = issue;
    assign cod_write        = issue & g_write;
    assign cod_read         = issue & g_read & ~g_write;
    assign cod_writedata    = issue ? g_wdata : '0;
    assign req0_waitrequest = ~(issue && (grant == REQ0));
    assign req1_waitrequest = ~(issue && (grant == REQ1));
    assign busy             = (state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= ST_IDLE;
            grant              <= REQ0;
            last               <= REQ1;
            lock_valid         <= 1'b0;
            lock_owner         <= REQ0;
            req0_readdata      <= '0;
            req1_readdata      <= '0;
            req0_readdatavalid <= 1'b0;
            req1_readdatavalid <= 1'b0;
        end else begin
            req0_readdatavalid <= 1'b0;
            req1_readdatavalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (lock_valid && !lock_in[lock_owner]) begin
                        lock_valid <= 1'b0;
                    end
                    if (|req_any) begin
                        grant <= pick;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    last <= grant;
                    if (g_lock) begin
                        lock_valid <= 1'b1;
                        lock_owner <= grant;
                    end
                    state <= (g_read && !g_write) ? ST_RDWAIT : ST_IDLE;
                end
                ST_RDWAIT: begin
                    if (grant == REQ1) begin
                        req1_readdata      <= cod_readdata;
                        req1_readdatavalid <= 1'b1;
                    end else begin
                        req0_readdata      <= cod_readdata;
                        req0_readdatavalid <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_arbiter.sv
// tb/tb_huffman_arbiter.sv - directed self-checking bench for huffman_arbiter
module tb_huffman_arbiter;

    typedef struct packed {
        logic        r0_rd, r0_wr, r0_lk;
        logic [31:0] r0_wd;
        logic        r1_rd, r1_wr, r1_lk;
        logic [31:0] r1_wd;
        logic [31:0] crdata;
    } in_t;

    typedef struct packed {
        logic        cs, crd, cwr;
        logic [31:0] cwd;
        logic        w0, w1, v0, v1;
        logic [31:0] rd0, rd1;
        logic        busy;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0_read = 1'b0, req0_write = 1'b0, req0_lock = 1'b0;
    logic [31:0] req0_writedata = '0;
    logic        req1_read = 1'b0, req1_write = 1'b0, req1_lock = 1'b0;
    logic [31:0] req1_writedata = '0;
    logic [31:0] cod_readdata = '0;
    logic        req0_waitrequest, req0_readdatavalid;
    logic        req1_waitrequest, req1_readdatavalid;
    logic [31:0] req0_readdata, req1_readdata, cod_writedata;
    logic        cod_chipselect, cod_read, cod_write, busy;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[13];

    huffman_arbiter #(.DATA_W(32)) dut (
        .clock              (clock),
        .reset              (reset),
        .req0_read          (req0_read),
        .req0_write         (req0_write),
        .req0_writedata     (req0_writedata),
        .req0_lock          (req0_lock),
        .req0_waitrequest   (req0_waitrequest),
        .req0_readdata      (req0_readdata),
        .req0_readdatavalid (req0_readdatavalid),
        .req1_read          (req1_read),
        .req1_write         (req1_write),
        .req1_writedata     (req1_writedata),
        .req1_lock          (req1_lock),
        .req1_waitrequest   (req1_waitrequest),
        .req1_readdata      (req1_readdata),
        .req1_readdatavalid (req1_readdatavalid),
        .cod_chipselect     (cod_chipselect),
        .cod_read           (cod_read),
        .cod_write          (cod_write),
        .cod_writedata      (cod_writedata),
        .cod_readdata       (cod_readdata),
        .busy               (busy)
    );

    always #5 clock = ~clock;

    function automatic in_t mk_in(logic r0rd, logic r0wr, logic [31:0] r0wd,
                                  logic r1rd, logic r1wr, logic [31:0] r1wd,
                                  logic [31:0] crdata);
        in_t t;
        t = '{r0rd, r0wr, 1'b0, r0wd, r1rd, r1wr, 1'b0, r1wd, crdata};
        return t;
    endfunction

    function automatic out_t mk_out(logic cs, logic crd, logic cwr, logic [31:0] cwd,
                                    logic w0, logic w1, logic v0, logic v1,
                                    logic [31:0] rd0, logic [31:0] rd1, logic bsy);
        out_t t;
        t = '{cs, crd, cwr, cwd, w0, w1, v0, v1, rd0, rd1, bsy};
        return t;
    endfunction

    function automatic out_t get_out();
        out_t t;
        t = '{cod_chipselect, cod_read, cod_write, cod_writedata,
              req0_waitrequest, req1_waitrequest, req0_readdatavalid, req1_readdatavalid,
              req0_readdata, req1_readdata, busy};
        return t;
    endfunction

    task automatic apply_in(input in_t t);
        req0_read = t.r0_rd; req0_write = t.r0_wr; req0_lock = t.r0_lk; req0_writedata = t.r0_wd;
        req1_read = t.r1_rd; req1_write = t.r1_wr; req1_lock = t.r1_lk; req1_writedata = t.r1_wd;
        cod_readdata = t.crdata;
    endtask

    task automatic check_out(input string name, input out_t exp);
        out_t got;
        got = get_out();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        apply_in('0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Each requester holds a write until accepted, then presents its next one.
    task automatic run_seq(input string name, input int lim0, input int lim1,
                           input logic lk0, input int n, input logic [7:0] order);
        int c0 = 0, c1 = 0, k = 0, cyc = 0;
        logic g;
        logic [31:0] expd;
        while (k < n && cyc < 100) begin
            @(posedge clock); #1;
            req0_write = (c0 < lim0); req0_writedata = 32'h100 + c0;
            req0_lock  = lk0 && (c0 < lim0);
            req1_write = (c1 < lim1); req1_writedata = 32'h200 + c1;
            @(negedge clock);
            if (cod_chipselect) begin
                g = req0_waitrequest;
                expd = order[k] ? 32'h200 + c1 : 32'h100 + c0;
                n_checks++;
                if (g !== order[k] || cod_writedata !== expd || cod_write !== 1'b1 ||
                    req0_waitrequest === req1_waitrequest) begin
                    n_fail++;
                    $display("FAIL %s txn%0d got grant=%0d data=%h exp grant=%0d data=%h",
                             name, k, g, cod_writedata, order[k], expd);
                end
                if (g) c1++; else c0++;
                k++;
            end
            if (req0_readdatavalid || req1_readdatavalid) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s spurious readdatavalid got=%b%b exp=00",
                         name, req1_readdatavalid, req0_readdatavalid);
            end
            cyc++;
        end
        apply_in('0);
        n_checks++;
        if (k < n) begin
            n_fail++;
            $display("FAIL %s timeout got %0d transactions exp %0d", name, k, n);
        end
    endtask

    initial begin
        // single write, read return, read+write collision
        vecs[0]  = '{mk_in(0,0,0, 0,0,0, 0),          mk_out(0,0,0,0, 1,1,0,0, 0,0, 0)};
        vecs[1]  = '{mk_in(0,1,32'hA5, 0,0,0, 0),     mk_out(0,0,0,0, 1,1,0,0, 0,0, 0)};
        vecs[2]  = '{mk_in(0,1,32'hA5, 0,0,0, 0),     mk_out(1,0,1,32'hA5, 0,1,0,0, 0,0, 1)};
        vecs[3]  = '{mk_in(0,0,0, 0,0,0, 0),          mk_out(0,0,0,0, 1,1,0,0, 0,0, 0)};
        vecs[4]  = '{mk_in(0,0,0, 1,0,0, 0),          mk_out(0,0,0,0, 1,1,0,0, 0,0, 0)};
        vecs[5]  = '{mk_in(0,0,0, 1,0,0, 0),          mk_out(1,1,0,0, 1,0,0,0, 0,0, 1)};
        vecs[6]  = '{mk_in(0,0,0, 0,0,0, 32'h1234),   mk_out(0,0,0,0, 1,1,0,0, 0,0, 1)};
        vecs[7]  = '{mk_in(0,0,0, 0,0,0, 0),          mk_out(0,0,0,0, 1,1,0,1, 0,32'h1234, 0)};
        vecs[8]  = '{mk_in(0,0,0, 0,0,0, 32'h5555),   mk_out(0,0,0,0, 1,1,0,0, 0,32'h1234, 0)};
        vecs[9]  = '{mk_in(1,1,32'h5A, 0,0,0, 0),     mk_out(0,0,0,0, 1,1,0,0, 0,32'h1234, 0)};
        vecs[10] = '{mk_in(1,1,32'h5A, 0,0,0, 0),     mk_out(1,0,1,32'h5A, 0,1,0,0, 0,32'h1234, 1)};
        vecs[11] = '{mk_in(0,0,0, 0,0,0, 32'h7777),   mk_out(0,0,0,0, 1,1,0,0, 0,32'h1234, 0)};
        vecs[12] = '{mk_in(0,0,0, 0,0,0, 0),          mk_out(0,0,0,0, 1,1,0,0, 0,32'h1234, 0)};

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            @(posedge clock); #1;
            apply_in(vecs[i].in);
            @(negedge clock);
            check_out($sformatf("vec%0d", i), vecs[i].exp);
        end

        do_reset();
        run_seq("alternate", 3, 3, 1'b0, 6, 8'b0010_1010);

        do_reset();
        run_seq("lock", 3, 1, 1'b1, 4, 8'b0000_1000);

        // reset landing in RDWAIT must swallow the pending read return
        @(posedge clock); #1;
        apply_in(mk_in(0,0,0, 1,0,0, 0));
        @(negedge clock);
        check_out("rst_rd_idle", mk_out(0,0,0,0, 1,1,0,0, 0,0, 0));
        @(posedge clock); #1;
        @(negedge clock);
        check_out("rst_rd_issue", mk_out(1,1,0,0, 1,0,0,0, 0,0, 1));
        @(posedge clock); #1;
        apply_in(mk_in(0,0,0, 0,0,0, 32'hBEEF));
        reset = 1'b1;
        @(negedge clock);
        check_out("rst_rd_wait", mk_out(0,0,0,0, 1,1,0,0, 0,0, 1));
        @(posedge clock); #1;
        reset = 1'b0;
        apply_in('0);
        @(negedge clock);
        check_out("rst_rd_after", mk_out(0,0,0,0, 1,1,0,0, 0,0, 0));
        @(posedge clock); #1;
        @(negedge clock);
        check_out("rst_rd_after2", mk_out(0,0,0,0, 1,1,0,0, 0,0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/huffman_arbiter.md
HUFFMAN_ARBITER -- requirements
Module: huffman_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of all data buses.
REQ-002 SHALL have port clock  in  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports reqN_read, reqN_write  in  1 each (N=0,1)  requester N read/write command, held until accepted.
REQ-005 SHALL have port reqN_writedata  in  DATA_W  requester N write data, stable while the command is held.
REQ-006 SHALL have port reqN_lock  in  1  requester N keeps the grant across consecutive transactions.
REQ-007 SHALL have port reqN_waitrequest  out  1  low only in the cycle requester N's command is accepted.
REQ-008 SHALL have ports reqN_readdata  out  DATA_W  and reqN_readdatavalid  out  1  read return to requester N.
REQ-009 SHALL have ports cod_chipselect, cod_read, cod_write  out  1 each  Avalon-MM command to the Huffman coder slave.
REQ-010 SHALL have port cod_writedata  out  DATA_W  write data to the coder.
REQ-011 SHALL have port cod_readdata  in  DATA_W  coder read data, valid one cycle after the read command.
REQ-012 SHALL have port busy  out  1  high when the state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, RDWAIT.
REQ-014 IDLE: if any requester has read or write high, SHALL register grant and go to ISSUE next cycle; otherwise stay in IDLE.
REQ-015 Grant selection SHALL follow this order: locked owner first, if its lock and its command are high; otherwise round-robin, preferring the requester not granted last; a single requester wins outright.
REQ-016 ISSUE: cod_chipselect=1, and cod_read/cod_write/cod_writedata SHALL be driven combinationally from the granted requester; grantee waitrequest=0 for exactly this cycle.
REQ-017 If read and write are both high, write SHALL win, with cod_read=0; the read is dropped and must be reissued by the requester.
REQ-018 ISSUE with write SHALL return to IDLE; ISSUE with read SHALL go to RDWAIT.
REQ-019 RDWAIT: cod_readdata SHALL be registered into reqN_readdata of the grantee, with reqN_readdatavalid=1 for one cycle the following cycle; then IDLE.
REQ-020 reqN_readdata SHALL hold its last value until the next read return to N.
REQ-021 Write latency SHALL be: command seen at cycle T, accepted at T+1, next IDLE at T+2; read data valid at T+3.
REQ-022 Outside ISSUE, all cod_* command outputs SHALL be 0, and cod_writedata SHALL be 0.
REQ-023 Lock ownership SHALL be set when a grantee is accepted with reqN_lock=1, and cleared in IDLE when the owner's lock is 0.
REQ-024 While a lock is held and the owner has no command, the other requester SHALL be served without clearing the lock.
REQ-025 The round-robin pointer SHALL update to the grantee on every ISSUE.
REQ-026 Simultaneous requests with no lock SHALL result in alternating grants: 0,1,0,1...
REQ-027 A non-granted requester SHALL see waitrequest=1 and SHALL never receive readdatavalid.

Reset
REQ-028 Reset SHALL force: state=IDLE, rr pointer preferring requester 0 next, lock owner none, all waitrequest=1, readdatavalid=0, readdata=0, cod_*=0, busy=0.
REQ-029 Reset asserted in RDWAIT SHALL suppress the pending readdatavalid.
REQ-030 Reset asserted in ISSUE SHALL take effect next cycle; a coder access in progress is not retracted.

Structure
REQ-031 Package huffman_arb_pkg SHALL hold the state enum, DATA_W default and requester-index constants.
REQ-032 Two-way round-robin/lock selection SHALL be one sub-module, rr_pick2, with inputs req[1:0], last, lock_owner_valid, lock_owner and output grant.

Verification
REQ-033 Req0 write 0xA5 alone -> cod_write=1 with data 0xA5 at T+1, req0_waitrequest=0 at T+1 only, busy=1 at T+1.
REQ-034 Req1 read, cod_readdata=0x1234 in RDWAIT -> req1_readdata=0x1234 with readdatavalid for one cycle at T+3; req0 sees no valid.
REQ-035 Both requesters write continuously for 6 transactions -> grant order 0,1,0,1,0,1, with data matching each requester.
REQ-036 Req0 lock=1 with 3 back-to-back writes while req1 writes -> req0 is served three times first, then req1.
REQ-037 Read and write both high on req0 -> only cod_write=1, no readdatavalid.
REQ-038 Reset pulsed in RDWAIT -> no readdatavalid, state IDLE, all waitrequest=1 next cycle.
